// File: rtl/suma_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   state_t   : controller states
//   DIGIT_W   : width of one packed BCD digit
//   BCD_MAX   : largest legal BCD digit value
//   bcd_valid : returns 1 when a nibble holds a legal BCD digit
package suma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        NEGATE,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction.
//   x, y : input digits (each 0..9 in normal use)
//   cin  : incoming decimal carry
//   sum  : corrected result digit (0..9)
//   cout : outgoing decimal carry
module bcd_digit_add
    import suma_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout
);

    localparam logic [DIGIT_W:0] TEN = (DIGIT_W+1)'(10);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] corrected;

    // Binary sum is at most 9+9+1 = 19, so a single subtract-10 always
    // brings it back into the 0..9 range.
    always_comb begin
        raw       = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, cin};
        corrected = raw;
        cout      = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            corrected = raw - TEN;
            cout      = 1'b1;
        end
        sum = corrected[DIGIT_W-1:0];
    end

endmodule

// File: rtl/module_suma_bcd_seq.sv
// Digit-serial BCD adder/subtractor, least significant digit first.
//   clk, rst : clock and asynchronous active-high reset
//   start    : request, only honoured while idle
//   sub      : 0 = a+b, 1 = a-b (captured with start)
//   a, b     : packed BCD operands, digit 0 in bits [3:0]
//   s        : packed BCD result, N_DIGITS+1 digits (magnitude when neg=1)
//   neg      : subtract result was negative
//   err      : an operand nibble was not a legal BCD digit
//   busy     : controller is not idle
//   done     : one-cycle completion pulse
module module_suma_bcd_seq
    import suma_pkg::*;
#(
    parameter int N_DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            sub,
    input  logic [DIGIT_W*N_DIGITS-1:0]     a,
    input  logic [DIGIT_W*N_DIGITS-1:0]     b,
    output logic [DIGIT_W*(N_DIGITS+1)-1:0] s,
    output logic                            neg,
    output logic                            err,
    output logic                            busy,
    output logic                            done
);

    localparam int IDX_W = $clog2(N_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t state;
    state_t next_state;

    logic [DIGIT_W*N_DIGITS-1:0] a_q;
    logic [DIGIT_W*N_DIGITS-1:0] b_q;
    logic                        sub_q;
    logic                        carry_q;
    logic [IDX_W-1:0]            idx_q;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] s_dig;
    logic [DIGIT_W-1:0] op_x;
    logic [DIGIT_W-1:0] op_y;
    logic [DIGIT_W-1:0] dig_sum;
    logic               dig_cout;
    logic               inputs_ok;
    logic               last_digit;

    assign a_dig      = a_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign b_dig      = b_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign s_dig      = s[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign last_digit = (idx_q == LAST_IDX);
    assign busy       = (state != IDLE);

    // Operands are screened on the raw inputs so a bad request can go
    // straight to DONE without spending any digit cycles.
    always_comb begin
        inputs_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!bcd_valid(a[i*DIGIT_W +: DIGIT_W]) ||
                !bcd_valid(b[i*DIGIT_W +: DIGIT_W])) begin
                inputs_ok = 1'b0;
            end
        end
    end

    // One digit adder serves both passes. ADD feeds a + b (or a + 9's
    // complement of b); NEGATE feeds the 9's complement of the partial
    // result plus the running carry, which forms its ten's complement.
    always_comb begin
        op_x = a_dig;
        op_y = sub_q ? (BCD_MAX - b_dig) : b_dig;
        if (state == NEGATE) begin
            op_x = BCD_MAX - s_dig;
            op_y = '0;
        end
    end

    bcd_digit_add u_digit_add (
        .x    (op_x),
        .y    (op_y),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE holds for two cycles: the first raises the registered done
    // pulse, the second (with done high) releases back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = inputs_ok ? ADD : DONE;
                end
            end
            ADD: begin
                if (last_digit) begin
                    next_state = (sub_q && !dig_cout) ? NEGATE : DONE;
                end
            end
            NEGATE: begin
                if (last_digit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A subtract with no carry out of the top digit means a < b; the
    // stored digits are then the ten's complement of the magnitude and
    // a second pass over s recovers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == DONE) && !done;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        idx_q   <= '0;
                        s       <= '0;
                        neg     <= 1'b0;
                        err     <= !inputs_ok;
                    end
                end
                ADD: begin
                    s[int'(idx_q)*DIGIT_W +: DIGIT_W] <= dig_sum;
                    carry_q <= dig_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_digit) begin
                        idx_q <= '0;
                        if (!sub_q) begin
                            s[N_DIGITS*DIGIT_W +: DIGIT_W] <= {{(DIGIT_W-1){1'b0}}, dig_cout};
                        end else if (dig_cout) begin
                            s[N_DIGITS*DIGIT_W +: DIGIT_W] <= '0;
                        end else begin
                            carry_q <= 1'b1;
                        end
                    end
                end
                NEGATE: begin
                    s[int'(idx_q)*DIGIT_W +: DIGIT_W] <= dig_sum;
                    carry_q <= dig_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_digit) begin
                        idx_q <= '0;
                        s[N_DIGITS*DIGIT_W +: DIGIT_W] <= '0;
                        neg   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/module_suma_bcd_seq.md
# module_suma_bcd_seq

Parametrised, digit-serial BCD adder/subtractor that replaces the fixed 12-bit combinational sum in the calculator datapath. It takes two N-digit packed BCD operands on a start strobe and processes one digit per clock, least significant digit first. It returns an (N+1)-digit result with sign and error flags and a one-cycle done pulse. It sits between the operand registers fed by the keypad capture logic and the display/result register.

## Interface
Parameters:
- N_DIGITS, 3, number of BCD digits per operand (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  mode: 0 = a+b, 1 = a−b; captured with start
- a  in  4·N_DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  in  4·N_DIGITS  operand B, packed BCD
- s  out  4·(N_DIGITS+1)  result, packed BCD; top digit is the carry digit (add) or 0 (sub)
- neg  out  1  result is negative (sub only); s holds the magnitude
- err  out  1  an input nibble was >9
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; s/neg/err valid from this cycle

## Operation
- FSM states: IDLE, ADD, NEGATE, DONE.
- IDLE, start=1:
  - Capture a, b and sub into internal registers.
  - Check every nibble of a and b. If any is >9, go to DONE with err=1, s=0, neg=0.
  - Otherwise clear the digit index and go to ADD. The carry starts at sub (1 for ten's complement).
- ADD: one digit per cycle.
  - digit_sum = a_i + (sub ? 9−b_i : b_i) + carry.
  - If digit_sum >9, subtract 10 and set carry=1.
  - Write the digit to s[i] and increment i.
  - After digit N−1:
    - add mode: s[N] = carry (0 or 1); go to DONE.
    - sub mode, carry=1: s[N]=0, neg=0; go to DONE.
    - sub mode, carry=0: go to NEGATE.
- NEGATE: N cycles, one digit per cycle.
  - Replace s with its ten's complement (9−s_i plus a carry initialised to 1, same correction rule).
  - Set neg=1 and s[N]=0, then go to DONE.
- DONE: assert done for one cycle, then return to IDLE.
- Outputs s, neg and err are registered. They hold their value until the next accepted start, and are cleared when that start is accepted.
- start is ignored while busy=1, including in the DONE cycle.
- Reset values: s=0, neg=0, err=0, busy=0, done=0, state IDLE.

## Timing
- Start sampled at edge k.
- Latency to done:
  - Add, or subtract with a non-negative result: done is high in the cycle after edge k+N+1.
  - Subtract with a negative result: k+2N+1.
  - Error: k+1.
- busy rises in the cycle after edge k and falls with the cycle following done.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at their reset values and no done pulse. The first start after reset release is processed normally.
- Width rule: the result is always N+1 digits. Add maximum is 10^N−2+... ≤ 2·(10^N−1), so it never overflows.

## Structure
- Package suma_pkg holds:
  - the state enum `state_t` (IDLE, ADD, NEGATE, DONE)
  - constants DIGIT_W=4 and BCD_MAX=9
  - a function `bcd_valid(nibble)`
- Sub-module bcd_digit_add: combinational. Inputs are two 4-bit digits and cin; outputs are a 4-bit digit and cout. It is used by both ADD and NEGATE through a shared operand mux.
- Digit index counter width: $clog2(N_DIGITS+1).

## Test plan
(All with N_DIGITS=3.)
- Add: a=0x130, b=0x100, sub=0 → s=0x0230, neg=0, err=0, done at start+4.
- Add with carry ripple: a=0x999, b=0x001 → s=0x1000, done at start+4.
- Subtract, positive: a=0x300, b=0x100, sub=1 → s=0x0200, neg=0, done at start+4.
- Subtract, negative: a=0x200, b=0x300, sub=1 → s=0x0100, neg=1, done at start+7. Also a=0x005, b=0x005 → s=0, neg=0.
- Invalid operand: a=0x1A0 → err=1, s=0, done at start+1. A second start pulse while busy during a valid add is ignored, and its result is unchanged.
- Reset asserted at start+2 of an add → done never pulses, all outputs 0. The next start (0x002+0x001) gives s=0x0003.
